// File: rtl/dbus_uncached_responder_if.sv
// ----------------------------------------------------------------------------
// dbus_uncached_responder_if
//
// Purpose:
//    Bundles the CPU uncached data-bus channel and the single-beat
//    req/gnt/rvalid memory port that the uncached responder bridges between.
//
// Signals:
//    CPU side    : uncached_read, uncached_write, address, wrdata, byteenable
//                  (to responder); uncached_stall, uncached_rddata (from it)
//    Memory side : mem_req, mem_we, mem_addr, mem_wdata, mem_be (from
//                  responder); mem_gnt, mem_rvalid, mem_rdata (to it)
//    Status      : bus_error (from responder, one-cycle read-timeout pulse)
//
// Modports:
//    slave  : the responder's view
//    master : the surrounding system's view (CPU plus interconnect)
// ----------------------------------------------------------------------------
interface dbus_uncached_responder_if;

   // CPU uncached channel
   logic        uncached_read;
   logic        uncached_write;
   logic [31:0] address;
   logic [31:0] wrdata;
   logic [3:0]  byteenable;
   logic        uncached_stall;
   logic [31:0] uncached_rddata;

   // Memory / MMIO interconnect port
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   // Read timeout indication
   logic        bus_error;

   modport slave (
      input  uncached_read,
      input  uncached_write,
      input  address,
      input  wrdata,
      input  byteenable,
      output uncached_stall,
      output uncached_rddata,
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      output mem_be,
      input  mem_gnt,
      input  mem_rvalid,
      input  mem_rdata,
      output bus_error
   );

   modport master (
      output uncached_read,
      output uncached_write,
      output address,
      output wrdata,
      output byteenable,
      input  uncached_stall,
      input  uncached_rddata,
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      input  mem_be,
      output mem_gnt,
      output mem_rvalid,
      output mem_rdata,
      input  bus_error
   );

endinterface

// File: rtl/dbus_uncached_responder.sv
// ----------------------------------------------------------------------------
// dbus_uncached_responder
//
// Purpose:
//    Slave endpoint of the CPU data-bus uncached channel. Each CPU uncached
//    access becomes one single-beat transaction on a req/gnt/rvalid memory
//    port toward the MMIO/peripheral interconnect.
//    - Writes are posted into a one-entry buffer and complete immediately
//      when the buffer is empty.
//    - Reads wait for any buffered write to retire first, so the memory port
//      always sees accesses in program order.
//    - A read that receives no rvalid within TIMEOUT_CYCLES cycles of its
//      grant completes with ERR_DATA and a one-cycle bus_error pulse.
//    Only one memory transaction is ever outstanding.
//
// Parameters:
//    TIMEOUT_CYCLES : max cycles spent waiting for rvalid (must be >= 1)
//    ERR_DATA       : read data returned on a timeout
//
// Ports:
//    clk    : clock, all state updates on the rising edge
//    rst_n  : asynchronous active-low reset
//    bus_if : slave modport of dbus_uncached_responder_if (CPU channel,
//             memory port and bus_error)
// ----------------------------------------------------------------------------
module dbus_uncached_responder #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input logic                       clk,
   input logic                       rst_n,
   dbus_uncached_responder_if.slave  bus_if
);

   // Counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_REQ  = 2'd1,
      RD_WAIT = 2'd2,
      RD_DONE = 2'd3
   } state_e;

   state_e           state_q,     state_d;
   logic             mem_req_q,   mem_req_d;
   logic             mem_we_q,    mem_we_d;
   logic [31:0]      mem_addr_q,  mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic [3:0]       mem_be_q,    mem_be_d;
   logic [31:0]      rddata_q,    rddata_d;
   logic             bus_error_q, bus_error_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;

   logic             stall;
   logic             wbuf_full;

   // The posted write buffer is the memory request register itself: a write
   // request that has not yet been granted is the buffered write. No separate
   // valid bit is kept, so buffer state and the mem port can never disagree.
   assign wbuf_full = mem_req_q & mem_we_q;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_be_q    <= 4'h0;
         rddata_q    <= 32'h0;
         bus_error_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         rddata_q    <= rddata_d;
         bus_error_q <= bus_error_d;
         cnt_q       <= cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and combinational outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      rddata_d    = rddata_q;
      bus_error_d = 1'b0;
      cnt_d       = cnt_q;
      stall       = 1'b0;

      // Buffered write retires in its grant cycle; the buffer reads empty
      // from the next cycle on.
      if (wbuf_full && bus_if.mem_gnt) begin
         mem_req_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            // Read takes priority, so an illegal read+write pair services
            // the read and drops the write.
            if (bus_if.uncached_read) begin
               stall = 1'b1;
               // Never let a read overtake a buffered write.
               if (!wbuf_full) begin
                  state_d    = RD_REQ;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = bus_if.address;
               end
            end else if (bus_if.uncached_write) begin
               // A write waiting on a full buffer is taken only once the
               // buffer reads empty, i.e. the cycle after the drain's grant.
               stall = wbuf_full;
               if (!wbuf_full) begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = bus_if.address;
                  mem_wdata_d = bus_if.wrdata;
                  mem_be_d    = bus_if.byteenable;
               end
            end
         end

         RD_REQ: begin
            stall = 1'b1;
            // rvalid is ignored here; it may only follow the grant.
            if (bus_if.mem_gnt) begin
               mem_req_d = 1'b0;
               state_d   = RD_WAIT;
               cnt_d     = '0;
            end
         end

         RD_WAIT: begin
            stall = 1'b1;
            // Data arriving in the last allowed cycle still wins over timeout.
            if (bus_if.mem_rvalid) begin
               rddata_d = bus_if.mem_rdata;
               state_d  = RD_DONE;
            end else if (cnt_q == CNT_LAST) begin
               rddata_d    = ERR_DATA;
               bus_error_d = 1'b1;
               state_d     = RD_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         RD_DONE: begin
            // The held read completes now; a late rvalid is simply dropped.
            stall   = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus_if.uncached_stall  = stall;
   assign bus_if.uncached_rddata = rddata_q;
   assign bus_if.mem_req         = mem_req_q;
   assign bus_if.mem_we          = mem_we_q;
   assign bus_if.mem_addr        = mem_addr_q;
   assign bus_if.mem_wdata       = mem_wdata_q;
   assign bus_if.mem_be          = mem_be_q;
   assign bus_if.bus_error       = bus_error_q;

endmodule

// File: doc/dbus_uncached_responder.md
Name: dbus_uncached_responder

Overview:
- Slave-side endpoint of the CPU data bus uncached channel (uncached_read/uncached_write/uncached_stall/uncached_rddata).
- Converts CPU uncached accesses into single-beat requests on a simple req/gnt/rvalid memory port toward the MMIO/peripheral interconnect.
- Contains a one-entry posted write buffer, preserves program order between uncached writes and reads, and bounds read latency with a timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in RD_WAIT before a read is aborted with an error (must be ≥1).
- ERR_DATA, 32'hDEAD_BEEF: value returned on uncached_rddata when a read times out.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- uncached_read  in  1  CPU uncached read request (held while uncached_stall=1)
- uncached_write  in  1  CPU uncached write request (held while uncached_stall=1)
- address  in  32  word address, 4-byte aligned
- wrdata  in  32  write data
- byteenable  in  4  write byte lanes
- uncached_stall  out  1  request not yet complete
- uncached_rddata  out  32  read data, valid in the completion cycle
- mem_req  out  1  memory request valid, registered
- mem_we  out  1  1 = write, registered
- mem_addr  out  32  registered
- mem_wdata  out  32  registered
- mem_be  out  4  registered
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data returned, single cycle
- mem_rdata  in  32  read data
- bus_error  out  1  one-cycle pulse on read timeout

Behaviour:
- Completion rule: a CPU request completes in the cycle it is asserted with uncached_stall=0. uncached_stall is combinational from inputs and state. The CPU may change its request in the following cycle.
- Reset: FSM=IDLE, write buffer empty, mem_req=0, mem_we=0, mem_addr/wdata/be=0, uncached_rddata=0, bus_error=0, timeout counter=0. Reset is asynchronous and may occur mid-transaction; any pending buffered write is discarded.
- FSM states: IDLE, RD_REQ, RD_WAIT, RD_DONE.
- IDLE + uncached_write:
  - Buffer empty: stall=0; the write completes this cycle and is captured into the buffer. mem_req=1, we=1 from the next cycle.
  - Buffer full: stall=1 until the buffer drains.
- IDLE + uncached_read:
  - Buffer empty: stall=1; go to RD_REQ; latch address; drive mem_req=1, we=0 from the next cycle.
  - Buffer full: stall=1; stay IDLE until the buffer is empty. Reads never bypass a buffered write.
- Both uncached_read and uncached_write asserted together is illegal. The read is serviced and the write is ignored; the bench flags it with an assertion.
- Buffer drain: the buffer holds mem_req=1 with stable fields until mem_gnt. The write is retired in the gnt cycle, so mem_req=0 the next cycle and the buffer is empty the next cycle. A write waiting on a full buffer is accepted in the first cycle the buffer reads empty.
- RD_REQ:
  - mem_req=1, stall=1.
  - On mem_gnt: mem_req=0 next cycle, go to RD_WAIT, clear the counter.
  - mem_rvalid in RD_REQ is ignored; rvalid must follow gnt by ≥1 cycle.
- RD_WAIT:
  - stall=1; counter increments each cycle.
  - On mem_rvalid: capture mem_rdata into uncached_rddata, go to RD_DONE.
  - When the counter reaches TIMEOUT_CYCLES-1 without rvalid: load ERR_DATA, pulse bus_error for one cycle, go to RD_DONE.
  - A late rvalid after a timeout, while in IDLE, RD_DONE, or RD_REQ, is dropped.
- RD_DONE: stall=0 (the read completes), uncached_rddata held; go to IDLE next cycle. A new request in the following cycle is handled as in IDLE.
- Minimum read latency with immediate gnt and rvalid one cycle later: request seen in cycle 0, completes in cycle 3.
- uncached_rddata holds its last value outside RD_DONE.
- Only one memory transaction is outstanding at any time.

Test Plan:
- Write then idle:
  - Stimulus: write addr=0x1FD0_03F8, wrdata=0x0000_00A5, be=4'b0001, mem_gnt tied 1.
  - Required: stall=0 in cycle 0. Cycle 1: mem_req=1, we=1, same addr/data/be. Cycle 2: mem_req=0.
- Back-to-back writes with gnt delayed 3 cycles:
  - Required: first write completes immediately; second stalls until the first's gnt; mem sees both in order, no duplication.
- Read with mem_gnt immediate, mem_rvalid one cycle later, rdata=0x1234_5678:
  - Required: stall high for cycles 0–2; completes in cycle 3 with uncached_rddata=0x1234_5678; mem_req high exactly one cycle.
- Write to 0x100 then read of 0x100, gnt delayed 2 cycles:
  - Required: read mem_req rises only after the write's gnt; order on the mem port is W then R.
- Read with no rvalid, TIMEOUT_CYCLES=8:
  - Required: bus_error one-cycle pulse; completion with uncached_rddata=0xDEAD_BEEF; a later stray rvalid is ignored and the next read returns its own data.
- rst_n low while in RD_WAIT with a buffered write pending:
  - Required: outputs immediately at reset values; after release, no mem_req is issued until a new CPU request.
